// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: decodes cs-framed SPI command bytes into reads/writes of a local register bank
module spi_reg_bridge #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W = 4,
  parameter logic [7:0] RESP_IDLE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  irq,
  input  logic                  irq_ack
);
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] CMD_ST = 8'h03;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DISCARD} state_t;
  state_t            r_state;
  logic [7:0]        r_cmd;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_regs [NUM_REGS];
  logic              r_cs_m, r_cs_s, r_cs_d;
  logic              r_wr_seen, r_err, r_irq;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              w_frame_end, w_act, w_irq_set;
  logic [ADDR_W-1:0] w_ptr_nx, w_addr;
  assign w_frame_end = r_cs_s & ~r_cs_d;
  // a byte arriving on the same cycle as frame_end still belongs to the frame
  assign w_act = rx_valid & (~r_cs_s | w_frame_end);
  assign w_irq_set = w_frame_end & (r_wr_seen | (w_act & (r_state == WDATA)));
  assign w_ptr_nx = r_ptr + 1'b1;
  assign w_addr = rx_data[ADDR_W-1:0];
  assign tx_data = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign irq = r_irq;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign regs_flat[8*i +: 8] = r_regs[i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cmd <= '0;
      r_ptr <= '0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      r_cs_m <= 1'b1;
      r_cs_s <= 1'b1;
      r_cs_d <= 1'b1;
      r_wr_seen <= 1'b0;
      r_err <= 1'b0;
      r_irq <= 1'b0;
      r_tx_data <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_cs_m <= cs;
      r_cs_s <= r_cs_m;
      r_cs_d <= r_cs_s;
      r_tx_valid <= w_act;
      if (w_act) begin
        case (r_state)
          IDLE: begin
            r_cmd <= rx_data;
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              r_state <= ADDR;
              r_tx_data <= RESP_IDLE;
            end else if (rx_data == CMD_ST) begin
              r_state <= DISCARD;
              r_tx_data <= {r_irq, r_err, 6'b0};
              r_err <= 1'b0;
            end else begin
              r_state <= DISCARD;
              r_tx_data <= RESP_IDLE;
              r_err <= 1'b1;
            end
          end
          ADDR: begin
            r_ptr <= w_addr;
            r_state <= (r_cmd == CMD_WR) ? WDATA : RDATA;
            r_tx_data <= (r_cmd == CMD_WR) ? RESP_IDLE : r_regs[w_addr];
          end
          WDATA: begin
            r_regs[r_ptr] <= rx_data;
            r_ptr <= w_ptr_nx;
            r_wr_seen <= 1'b1;
            r_tx_data <= 8'h00;
          end
          RDATA: begin
            r_ptr <= w_ptr_nx;
            r_tx_data <= r_regs[w_ptr_nx];
          end
          default: r_tx_data <= 8'h00;
        endcase
      end
      if (w_frame_end) begin
        r_state <= IDLE;
        r_ptr <= '0;
        r_wr_seen <= 1'b0;
      end
      r_irq <= w_irq_set | (r_irq & ~irq_ack);
    end
  end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: scoreboard bench for spi_reg_bridge
module tb_spi_reg_bridge;
  localparam int N = 16;
  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cs = 1'b1;
  logic [7:0]     rx_data = '0;
  logic           rx_valid = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic [N*8-1:0] regs_flat;
  logic           irq;
  logic           irq_ack = 1'b0;
  int             n_tests = 0;
  int             n_fail = 0;
  logic [7:0]     sb_q [$];
  spi_reg_bridge dut (
    .clk(clk), .rst(rst), .cs(cs), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .regs_flat(regs_flat),
    .irq(irq), .irq_ack(irq_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] reg_at(input int i);
    return regs_flat[8*i +: 8];
  endfunction
  always @(negedge clk) begin
    if (rst && tx_valid) begin
      if (sb_q.size() == 0) chk("tx_unexpected", 1, 0);
      else chk("tx_data", {24'b0, tx_data}, {24'b0, sb_q.pop_front()});
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic [7:0] e, input bit push);
    rx_data = b;
    rx_valid = 1'b1;
    if (push) sb_q.push_back(e);
    tick(1);
    rx_valid = 1'b0;
    tick(1);
  endtask
  task automatic frame_open();
    cs = 1'b0;
    tick(3);
  endtask
  task automatic frame_close();
    cs = 1'b1;
    tick(4);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("reset_irq", irq, 0);
    chk("reset_regs", regs_flat == '0, 1);
    frame_open();
    send(8'h01, 8'hA5, 1);
    send(8'h00, 8'hA5, 1);
    send(8'hAA, 8'h00, 1);
    frame_close();
    chk("pre_reg0", reg_at(0), 8'hAA);
    chk("pre_irq", irq, 1);
    frame_open();
    send(8'h01, 8'hA5, 1);
    send(8'h03, 8'hA5, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_regs", regs_flat == '0, 1);
    chk("midreset_irq", irq, 0);
    chk("midreset_txv", tx_valid, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    frame_close();
    frame_open();
    send(8'h01, 8'hA5, 1);
    send(8'h02, 8'hA5, 1);
    send(8'h77, 8'h00, 1);
    frame_close();
    chk("post_reset_reg2", reg_at(2), 8'h77);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    chk("post_reset_ack", irq, 0);
    frame_open();
    send(8'h01, 8'hA5, 1);
    send(8'h0E, 8'hA5, 1);
    send(8'h11, 8'h00, 1);
    send(8'h22, 8'h00, 1);
    rx_data = 8'h33;
    rx_valid = 1'b1;
    sb_q.push_back(8'h00);
    tick(1);
    rx_valid = 1'b0;
    chk("wr_visible", reg_at(0), 8'h33);
    tick(1);
    cs = 1'b1;
    tick(2);
    @(negedge clk);
    chk("irq_not_yet", irq, 0);
    @(negedge clk);
    chk("irq_3cyc", irq, 1);
    tick(2);
    chk("reg14", reg_at(14), 8'h11);
    chk("reg15", reg_at(15), 8'h22);
    chk("reg0_wrap", reg_at(0), 8'h33);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    chk("irq_ack_alone", irq, 0);
    frame_open();
    send(8'h01, 8'hA5, 1);
    send(8'h03, 8'hA5, 1);
    send(8'h5A, 8'h00, 1);
    send(8'hC3, 8'h00, 1);
    frame_close();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    frame_open();
    send(8'h02, 8'hA5, 1);
    send(8'hF3, 8'h5A, 1);
    send(8'hEE, 8'hC3, 1);
    send(8'hEE, 8'h00, 1);
    frame_close();
    chk("read_no_irq", irq, 0);
    frame_open();
    send(8'h7F, 8'hA5, 1);
    send(8'h01, 8'h00, 1);
    frame_close();
    frame_open();
    send(8'h03, 8'h40, 1);
    frame_close();
    frame_open();
    send(8'h03, 8'h00, 1);
    frame_close();
    frame_open();
    send(8'h01, 8'hA5, 1);
    send(8'h08, 8'hA5, 1);
    send(8'h99, 8'h00, 1);
    cs = 1'b1;
    tick(2);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    chk("irq_set_wins", irq, 1);
    chk("reg8", reg_at(8), 8'h99);
    tick(2);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    frame_open();
    send(8'h01, 8'hA5, 1);
    frame_close();
    chk("cmd_only_no_irq", irq, 0);
    frame_open();
    send(8'h01, 8'hA5, 1);
    send(8'h05, 8'hA5, 1);
    frame_close();
    chk("addr_only_no_irq", irq, 0);
    chk("addr_only_reg5", reg_at(5), 8'h00);
    send(8'h01, 8'h00, 0);
    send(8'h02, 8'h00, 0);
    frame_open();
    send(8'h02, 8'hA5, 1);
    send(8'h0F, 8'h22, 1);
    send(8'h00, 8'h33, 1);
    frame_close();
    tick(2);
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
